// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution dot-product engine.
// Build option CONV_DOT_ENGINE_SIGNED_EN (consumed by the engine files) selects signed arithmetic.
package conv_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TAPS   = 36;
  localparam int DEF_LANES  = 6;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

  // Full-precision dot-product width: product width plus growth for TAPS terms.
  function automatic int sum_width(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// LANES parallel multipliers with a registered product stage and a combinational lane adder.
// CONV_DOT_ENGINE_SIGNED_EN selects two's-complement operands and sign extension.
module conv_lane_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  localparam int PROD_W = 2 * DATA_W,
  localparam int LSUM_W = PROD_W + $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      en_i,
  input  logic [LANES*DATA_W-1:0]   a_i,
  input  logic [LANES*DATA_W-1:0]   b_i,
  output logic [LSUM_W-1:0]         sum_o
);

  logic [PROD_W-1:0] prod_q [LANES];

  function automatic logic [PROD_W-1:0] mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef CONV_DOT_ENGINE_SIGNED_EN
    logic signed [PROD_W-1:0] sa;
    logic signed [PROD_W-1:0] sb;
    sa = PROD_W'($signed(a));
    sb = PROD_W'($signed(b));
    return sa * sb;
`else
    logic [PROD_W-1:0] ua;
    logic [PROD_W-1:0] ub;
    ua = PROD_W'(a);
    ub = PROD_W'(b);
    return ua * ub;
`endif
  endfunction

  function automatic logic [LSUM_W-1:0] ext(input logic [PROD_W-1:0] p);
`ifdef CONV_DOT_ENGINE_SIGNED_EN
    return LSUM_W'($signed(p));
`else
    return LSUM_W'(p);
`endif
  endfunction

  // Product stage: operands and products are data only, so no reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int k = 0; k < LANES; k++) begin
        prod_q[k] <= mul(a_i[k*DATA_W +: DATA_W], b_i[k*DATA_W +: DATA_W]);
      end
    end
  end

  // Lane adder over the registered products.
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_o = sum_o + ext(prod_q[k]);
    end
  end

endmodule

// File: rtl/conv_dot_engine.sv
// Window-buffered dot-product engine: LOAD -> COMPUTE -> DRAIN -> OUT with held valid/ready result.
// Define CONV_DOT_ENGINE_SIGNED_EN for two's-complement operands and a sign-extended result.
module conv_dot_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int LANES  = DEF_LANES,
  parameter int SUM_W  = sum_width(DATA_W, TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] image,
  input  logic [DATA_W-1:0] pattern,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  conv_sum,
  output logic              busy
);

  localparam int G      = TAPS / LANES;
  localparam int CW     = $clog2(TAPS);
  localparam int GW     = (G > 1) ? $clog2(G) : 1;
  localparam int LSUM_W = 2 * DATA_W + $clog2(LANES);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  conv_sum_q, conv_sum_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] ibuf_q [TAPS];
  logic [DATA_W-1:0] pbuf_q [TAPS];

  logic                    accept_s;
  logic [LANES*DATA_W-1:0] lane_a_s, lane_b_s;
  logic [LSUM_W-1:0]       lane_sum_s;

  function automatic logic [SUM_W-1:0] ext_sum(input logic [LSUM_W-1:0] s);
`ifdef CONV_DOT_ENGINE_SIGNED_EN
    return SUM_W'($signed(s));
`else
    return SUM_W'(s);
`endif
  endfunction

  assign accept_s = in_valid && (state_q == ST_LOAD);

  // Window buffers, written in arrival order.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      ibuf_q[count_q] <= image;
      pbuf_q[count_q] <= pattern;
    end
  end

  // Select the current group of LANES taps for the multipliers.
  always_comb begin
    lane_a_s = '0;
    lane_b_s = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_a_s[k*DATA_W +: DATA_W] = ibuf_q[int'(grp_q) * LANES + k];
      lane_b_s[k*DATA_W +: DATA_W] = pbuf_q[int'(grp_q) * LANES + k];
    end
  end

  conv_lane_mac #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_mac (
    .clk   (clk),
    .en_i  (state_q == ST_COMPUTE),
    .a_i   (lane_a_s),
    .b_i   (lane_b_s),
    .sum_o (lane_sum_s)
  );

  // Next-state and output-register logic; products land one cycle after their group is issued.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    grp_d       = grp_q;
    acc_d       = acc_q;
    conv_sum_d  = conv_sum_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          if (count_q == CW'(TAPS - 1)) begin
            state_d = ST_COMPUTE;
            count_d = CW'(0);
            grp_d   = GW'(0);
            acc_d   = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          count_d = count_q;
        end
      end
      ST_COMPUTE: begin
        if (grp_q != GW'(0)) begin
          acc_d = acc_q + ext_sum(lane_sum_s);
        end else begin
          acc_d = acc_q;
        end
        if (grp_q == GW'(G - 1)) begin
          state_d = ST_DRAIN;
          grp_d   = GW'(0);
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      ST_DRAIN: begin
        acc_d   = acc_q + ext_sum(lane_sum_s);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          conv_sum_d  = acc_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_LOAD;
          acc_d       = '0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_LOAD;
        count_d     = CW'(0);
        grp_d       = GW'(0);
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_LOAD);
    busy_d     = !((state_d == ST_LOAD) && (count_d == CW'(0)));
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      count_q     <= CW'(0);
      grp_q       <= GW'(0);
      acc_q       <= '0;
      conv_sum_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      grp_q       <= grp_d;
      acc_q       <= acc_d;
      conv_sum_q  <= conv_sum_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign conv_sum  = conv_sum_q;
  assign busy      = busy_q;

endmodule
